// File: rtl/sprite_loader.sv
// Unpacks a host byte stream (4 pixels per byte) into the sprite memory and serves renderer reads.
// Write latency: byte handshake -> 4 pixel writes over the next 4 cycles; read latency 1 cycle; byte_ready only in ACCEPT.
module sprite_loader #(
    parameter int DEPTH  = 1152,
    parameter int PIX_W  = 2,
    parameter int ADDR_W = 11
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_start,
    input  logic [7:0]        i_byte_in,
    input  logic              i_byte_valid,
    output logic              o_byte_ready,
    output logic              o_busy,
    output logic              o_done,
    input  logic [ADDR_W-1:0] i_read_address,
    output logic [PIX_W-1:0]  o_data_out
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCEPT = 2'd1,
        S_UNPACK = 2'd2,
        S_DONE   = 2'd3
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] DEPTH_A   = ADDR_W'(DEPTH);

    state_t              r_state;
    state_t              w_next;
    logic [ADDR_W-1:0]   r_wa;
    logic [1:0]          r_k;
    logic [7:0]          r_byte;
    logic [PIX_W-1:0]    r_mem [DEPTH];
    logic [PIX_W-1:0]    r_data;
    logic [2:0]          w_shift;
    logic [PIX_W-1:0]    w_pix;
    logic                w_write;
    logic                w_accept;

    assign w_shift  = {r_k, 1'b0};
    assign w_pix    = r_byte[w_shift +: PIX_W];
    assign w_write  = (r_state == S_UNPACK) && !i_reset;
    assign w_accept = (r_state == S_ACCEPT) && i_byte_valid;

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next       = r_state;
        o_byte_ready = 1'b0;
        o_busy       = 1'b0;
        o_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_next = S_ACCEPT;
                end
            end
            S_ACCEPT: begin
                o_byte_ready = 1'b1;
                o_busy       = 1'b1;
                if (i_byte_valid) begin
                    w_next = S_UNPACK;
                end
            end
            S_UNPACK: begin
                o_busy = 1'b1;
                // The fourth pixel of a byte decides whether the frame is complete.
                if (r_k == 2'd3) begin
                    w_next = (r_wa == LAST_ADDR) ? S_DONE : S_ACCEPT;
                end
            end
            S_DONE: begin
                o_done = 1'b1;
                w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_wa   <= '0;
            r_k    <= '0;
            r_byte <= '0;
        end else begin
            if ((r_state == S_IDLE) && i_start) begin
                r_wa <= '0;
            end
            if (w_accept) begin
                r_byte <= i_byte_in;
                r_k    <= '0;
            end
            if (r_state == S_UNPACK) begin
                r_wa <= r_wa + 1'b1;
                r_k  <= r_k + 1'b1;
            end
        end
    end

    // Memory is deliberately outside reset so an abandoned load keeps what it wrote.
    always_ff @(posedge i_clk) begin
        if (w_write) begin
            r_mem[r_wa] <= w_pix;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_data <= '0;
        end else if (i_read_address < DEPTH_A) begin
            r_data <= r_mem[i_read_address];
        end else begin
            r_data <= '0;
        end
    end

    assign o_data_out = r_data;

endmodule
